// File: rtl/decodificador_pwm.sv
// PWM receiver: measures high time and period of each PWM cycle and decodes
// the high time back into the 2-bit width code, with tolerance and stuck-line checks.
module decodificador_pwm #(
  parameter int unsigned conf_periodo = 1250,
  parameter int unsigned largura_00   = 0,
  parameter int unsigned largura_01   = 250,
  parameter int unsigned largura_10   = 500,
  parameter int unsigned largura_11   = 750,
  parameter int unsigned tolerancia   = 20,
  parameter int unsigned timeout      = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [1:0]  largura,
  output logic [31:0] medida,
  output logic [31:0] periodo_medido,
  output logic        pronto,
  output logic        erro,
  output logic [1:0]  db_estado
);

  localparam logic [1:0] ESPERA = 2'd0;
  localparam logic [1:0] ALTO   = 2'd1;
  localparam logic [1:0] BAIXO  = 2'd2;

  localparam logic [31:0] PERIODO_NOM = 32'(conf_periodo);
  localparam logic [31:0] LARG_00     = 32'(largura_00);
  localparam logic [31:0] LARG_01     = 32'(largura_01);
  localparam logic [31:0] LARG_10     = 32'(largura_10);
  localparam logic [31:0] LARG_11     = 32'(largura_11);
  localparam logic [31:0] TOL         = 32'(tolerancia);
  localparam logic [31:0] TIMEOUT_CNT = 32'(timeout);
  localparam logic [31:0] CNT_MAX     = '1;

  logic s1_q, s2_q, s3_q;
  logic [1:0]  estado_q, estado_d;
  logic [31:0] cnt_per_q, cnt_per_d;
  logic [31:0] cnt_alto_q, cnt_alto_d;
  logic [1:0]  largura_q, largura_d;
  logic [31:0] medida_q, medida_d;
  logic [31:0] periodo_q, periodo_d;
  logic        pronto_q, pronto_d;
  logic        erro_q, erro_d;

  logic rise, fall, timeout_hit;
  logic load_start, close_period, go_timeout;
  logic periodo_ok, largura_match;
  logic [1:0] codigo;
  logic [31:0] cnt_per_inc, cnt_alto_inc;

  // Absolute difference taken in the order that cannot underflow.
  function automatic logic dentro_tol(input logic [31:0] valor, input logic [31:0] nominal);
    logic [31:0] diff;
    diff = (valor >= nominal) ? (valor - nominal) : (nominal - valor);
    return diff <= TOL;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples its predecessor's old value, forming a real 3-stage chain.
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign timeout_hit = (cnt_per_q >= TIMEOUT_CNT);

  assign cnt_per_inc  = (cnt_per_q  == CNT_MAX) ? cnt_per_q  : cnt_per_q  + 32'd1;
  assign cnt_alto_inc = (cnt_alto_q == CNT_MAX) ? cnt_alto_q : cnt_alto_q + 32'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    estado_d     = estado_q;
    load_start   = 1'b0;
    close_period = 1'b0;
    go_timeout   = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (rise)             load_start = 1'b1;
        else if (timeout_hit) go_timeout = 1'b1;
      end
      ALTO: begin
        if (timeout_hit) go_timeout = 1'b1;
        else if (fall)   estado_d   = BAIXO;
      end
      BAIXO: begin
        if (rise) begin
          load_start   = 1'b1;
          close_period = 1'b1;
        end else if (timeout_hit) begin
          go_timeout = 1'b1;
        end
      end
      default: estado_d = ESPERA;
    endcase
    if (load_start) estado_d = ALTO;
    if (go_timeout) estado_d = ESPERA;
  end

  always_comb begin
    periodo_ok    = dentro_tol(cnt_per_q, PERIODO_NOM);
    largura_match = 1'b1;
    codigo        = 2'b00;
    // Lowest matching code wins.
    if (dentro_tol(cnt_alto_q, LARG_00))      codigo = 2'b00;
    else if (dentro_tol(cnt_alto_q, LARG_01)) codigo = 2'b01;
    else if (dentro_tol(cnt_alto_q, LARG_10)) codigo = 2'b10;
    else if (dentro_tol(cnt_alto_q, LARG_11)) codigo = 2'b11;
    else                                      largura_match = 1'b0;
  end

  always_comb begin
    cnt_per_d  = (estado_q == 2'd3) ? 32'd0 : cnt_per_inc;
    cnt_alto_d = (estado_q == ALTO && s2_q) ? cnt_alto_inc : cnt_alto_q;
    largura_d  = largura_q;
    medida_d   = medida_q;
    periodo_d  = periodo_q;
    erro_d     = erro_q;
    pronto_d   = 1'b0;

    if (load_start) begin
      cnt_per_d  = 32'd1;
      cnt_alto_d = 32'd1;
    end

    if (close_period) begin
      medida_d  = cnt_alto_q;
      periodo_d = cnt_per_q;
      pronto_d  = 1'b1;
      if (periodo_ok && largura_match) begin
        largura_d = codigo;
        erro_d    = 1'b0;
      end else begin
        erro_d = 1'b1;
      end
    end

    // Constant-low line is the generator's encoding of width 0; constant-high is a fault.
    if (go_timeout) begin
      cnt_per_d  = 32'd0;
      cnt_alto_d = 32'd0;
      periodo_d  = TIMEOUT_CNT;
      pronto_d   = 1'b1;
      if (s2_q) begin
        medida_d = TIMEOUT_CNT;
        erro_d   = 1'b1;
      end else begin
        largura_d = 2'b00;
        medida_d  = 32'd0;
        erro_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ESPERA;
      cnt_per_q  <= 32'd0;
      cnt_alto_q <= 32'd0;
      largura_q  <= 2'b00;
      medida_q   <= 32'd0;
      periodo_q  <= 32'd0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_per_q  <= cnt_per_d;
      cnt_alto_q <= cnt_alto_d;
      largura_q  <= largura_d;
      medida_q   <= medida_d;
      periodo_q  <= periodo_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
    end
  end

  assign largura        = largura_q;
  assign medida         = medida_q;
  assign periodo_medido = periodo_q;
  assign pronto         = pronto_q;
  assign erro           = erro_q;
  assign db_estado      = estado_q;

endmodule
